conv3x3_top: RTL and testbench
==============================

# conv3x3_top

Single-channel 3x3 "valid" convolution stage that sits directly upstream of the 2x2 max-pool/ReLU stage. On `run` it loads a 3x3 signed fixed-point kernel from a weight memory, then slides the window over an IN_WIDTH x IN_HEIGHT feature map held in a synchronous RAM. For each output pixel it writes one saturated, bias-added result to the output RAM in raster order. The output RAM is the input memory of the pooling stage, so the output map is (IN_WIDTH-2) x (IN_HEIGHT-2) and must have even dimensions.

## Interface
- IN_WIDTH, 6, input map width in pixels (>=3; IN_WIDTH-2 even)
- IN_HEIGHT, 6, input map height in pixels (>=3; IN_HEIGHT-2 even)
- DATA_WIDTH, 16, signed fixed-point word width for data, weights, bias and result
- FRAC_BITS, 8, fractional bits of the fixed-point format
- ADDR_WIDTH, 10, address width of the data and output RAMs
- clk  input  1  clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-high; clears all state
- run  input  1  start pulse; sampled only in STATE_WAIT
- data_in  input  DATA_WIDTH  signed input pixel; valid 1 cycle after read_address_out
- read_address_out  output  ADDR_WIDTH  input-map read address
- weight_in  input  DATA_WIDTH  signed kernel weight; valid 1 cycle after weight_address_out
- weight_address_out  output  4  kernel read address, 0..8 in raster order
- bias_in  input  DATA_WIDTH  signed bias; held stable by the controller for the whole run
- result_out  output  DATA_WIDTH  signed saturated convolution result
- write_address_out  output  ADDR_WIDTH  output-map write address
- we_out  output  1  one-cycle write strobe for result_out/write_address_out
- conv_done  output  1  one-cycle pulse when the whole map is finished

## Operation
- States: STATE_WAIT, STATE_LOAD_WEIGHTS, STATE_STREAM_DATA, STATE_DRAIN, STATE_WRITE, STATE_FINISHED.
- STATE_WAIT:
  - On `run`, go to STATE_LOAD_WEIGHTS.
  - Clear the column, row and output-address counters and the accumulator.
- STATE_LOAD_WEIGHTS:
  - Issue weight_address_out 0..8 on 9 consecutive cycles, then hold one extra cycle (10 cycles in total).
  - Capture weight_in into kernel register k[i] one cycle after address i is issued.
  - Then go to STATE_STREAM_DATA.
- STATE_STREAM_DATA:
  - Lasts 9 cycles.
  - Issue read_address_out = base + r*IN_WIDTH + c, for r,c in 0..2, raster order.
  - base = row*IN_WIDTH + col, the window's top-left pixel.
  - Each cycle in which a data word is valid, do acc += data_in * k[j].
  - Then go to STATE_DRAIN.
- STATE_DRAIN:
  - One cycle; the 9th product is accumulated here.
  - Then go to STATE_WRITE.
- STATE_WRITE:
  - we_out=1 for one cycle.
  - result_out = sat((acc + (bias_in <<< FRAC_BITS)) >>> FRAC_BITS).
  - write_address_out = current output index.
  - Then:
    - Clear acc and increment the output index.
    - Advance col by 1; at col = IN_WIDTH-3, wrap col to 0 and increment row.
    - If the window was the last one (col=IN_WIDTH-3, row=IN_HEIGHT-3), go to STATE_FINISHED; otherwise go to STATE_STREAM_DATA.
- STATE_FINISHED:
  - conv_done=1 for one cycle, then go to STATE_WAIT.
- Arithmetic:
  - Products are 2*DATA_WIDTH signed.
  - Accumulator is 2*DATA_WIDTH+4 signed, so it cannot overflow over 9 products plus the bias.
  - The shift is arithmetic and truncates toward minus infinity.
  - Saturation clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- `run` asserted outside STATE_WAIT is ignored.
- Weights are reloaded on every run.

## Timing
- Reset (asynchronous, any state):
  - Return to STATE_WAIT.
  - Zero all of: result_out, write_address_out, read_address_out, weight_address_out, we_out, conv_done, counters, accumulator, kernel registers.
  - A reset mid-run discards the partial map; no further we_out pulses occur.
- Read latency is exactly 1 cycle for both RAMs; the block never stalls.
- Cycles per output pixel: 11 (9 stream + 1 drain + 1 write).
- Run cycle count:
  - N = (IN_WIDTH-2)*(IN_HEIGHT-2) outputs.
  - conv_done rises 1 + 10 + 11*N cycles after the cycle `run` is sampled.
- Output write addresses run 0..N-1 consecutively, one per 11 cycles.
- read_address_out holds its last value when not in STATE_STREAM_DATA.
- A new `run` is accepted in the cycle after conv_done.

## Test plan
- Identity kernel:
  - Stimulus: 4x4 map with pixel[i]=i<<8, k[4]=256 (other weights 0), bias 0.
  - Required: 2x2 output = 5,6,9,10 (each <<8) at write addresses 0..3; conv_done 1+10+44 cycles after `run`.
- All-ones kernel:
  - Stimulus: every weight 256, every pixel 256, 6x6 map.
  - Required: all 16 outputs = 2304; window read addresses for output 5 are 7,8,9,13,14,15,19,20,21.
- Saturation:
  - Stimulus: every pixel 0x7FFF, every weight 0x7FFF.
  - Required: every result = 0x7FFF.
  - Stimulus: every weight 0x8000.
  - Required: every result = 0x8000.
- Bias and truncation:
  - Stimulus: k[4]=128 (0.5), pixel value 1 (raw), bias -256.
  - Required: result = -256 (truncation floor of -255.5/256 scaling).
- Reset mid-run:
  - Stimulus: assert reset during output 2's STATE_STREAM_DATA.
  - Required: all outputs 0 immediately; no we_out pulses afterwards.
  - Follow-up: a fresh `run` produces a correct full map.
- Back-to-back runs:
  - Stimulus: assert `run` the cycle after conv_done, with a different kernel.
  - Required: the second map uses only the new weights; write addresses restart at 0; `run` pulses during busy are ignored.

Source files
------------

// File: rtl/conv3x3_top.sv
// 3x3 valid convolution: loads a signed fixed-point kernel, slides the window over the
// input map and writes saturated, bias-added results in raster order.
module conv3x3_top #(
  parameter int unsigned IN_WIDTH   = 6,
  parameter int unsigned IN_HEIGHT  = 6,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic        [ADDR_WIDTH-1:0] read_address_out,
  input  logic signed [DATA_WIDTH-1:0] weight_in,
  output logic        [3:0]            weight_address_out,
  input  logic signed [DATA_WIDTH-1:0] bias_in,
  output logic signed [DATA_WIDTH-1:0] result_out,
  output logic        [ADDR_WIDTH-1:0] write_address_out,
  output logic                         we_out,
  output logic                         conv_done
);

  localparam int unsigned PROD_W   = 2 * DATA_WIDTH;
  localparam int unsigned ACC_W    = 2 * DATA_WIDTH + 4;
  localparam int unsigned COL_LAST = IN_WIDTH - 3;
  localparam int unsigned ROW_LAST = IN_HEIGHT - 3;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    STATE_WAIT,
    STATE_LOAD_WEIGHTS,
    STATE_STREAM_DATA,
    STATE_DRAIN,
    STATE_WRITE,
    STATE_FINISHED
  } state_t;

  state_t                         state, state_n;
  logic        [3:0]              cnt, cnt_n;
  logic        [ADDR_WIDTH-1:0]   col, col_n, row, row_n, out_idx, idx_n;
  logic signed [ACC_W-1:0]        acc, acc_n;
  logic signed [DATA_WIDTH-1:0]   kernel [9];

  logic        [3:0]              tap_c;
  logic signed [PROD_W-1:0]       prod_c;
  logic signed [ACC_W-1:0]        sum_c, shifted_c;
  logic signed [DATA_WIDTH-1:0]   sat_c;
  logic        [ADDR_WIDTH-1:0]   rd_addr_c;

  // Offset of window tap t (raster order) from the window's top-left pixel.
  function automatic logic [ADDR_WIDTH-1:0] tap_offset(input logic [3:0] t);
    logic [1:0] tr, tc;
    tr = 2'd0;
    tc = 2'd0;
    case (t)
      4'd1: tc = 2'd1;
      4'd2: tc = 2'd2;
      4'd3: tr = 2'd1;
      4'd4: begin tr = 2'd1; tc = 2'd1; end
      4'd5: begin tr = 2'd1; tc = 2'd2; end
      4'd6: tr = 2'd2;
      4'd7: begin tr = 2'd2; tc = 2'd1; end
      4'd8: begin tr = 2'd2; tc = 2'd2; end
      default: ;
    endcase
    return ADDR_WIDTH'(tr) * ADDR_WIDTH'(IN_WIDTH) + ADDR_WIDTH'(tc);
  endfunction

  // Data word arriving now belongs to the tap issued one cycle earlier.
  always_comb begin
    tap_c = 4'd8;
    if (state == STATE_STREAM_DATA && cnt != 4'd0) tap_c = 4'(cnt - 4'd1);
    prod_c = PROD_W'(data_in) * PROD_W'(kernel[tap_c]);
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    col_n   = col;
    row_n   = row;
    idx_n   = out_idx;
    acc_n   = acc;
    case (state)
      STATE_WAIT: begin
        cnt_n = 4'd0;
        col_n = '0;
        row_n = '0;
        idx_n = '0;
        acc_n = '0;
        if (run) state_n = STATE_LOAD_WEIGHTS;
      end
      STATE_LOAD_WEIGHTS: begin
        cnt_n = 4'(cnt + 4'd1);
        if (cnt == 4'd9) begin
          cnt_n   = 4'd0;
          state_n = STATE_STREAM_DATA;
        end
      end
      STATE_STREAM_DATA: begin
        cnt_n = 4'(cnt + 4'd1);
        if (cnt != 4'd0) acc_n = acc + ACC_W'(prod_c);
        if (cnt == 4'd8) begin
          cnt_n   = 4'd0;
          state_n = STATE_DRAIN;
        end
      end
      STATE_DRAIN: begin
        acc_n   = acc + ACC_W'(prod_c);
        state_n = STATE_WRITE;
      end
      STATE_WRITE: begin
        acc_n = '0;
        idx_n = ADDR_WIDTH'(out_idx + 1'b1);
        if (col == ADDR_WIDTH'(COL_LAST)) begin
          col_n = '0;
          row_n = ADDR_WIDTH'(row + 1'b1);
        end else begin
          col_n = ADDR_WIDTH'(col + 1'b1);
        end
        if (col == ADDR_WIDTH'(COL_LAST) && row == ADDR_WIDTH'(ROW_LAST))
          state_n = STATE_FINISHED;
        else
          state_n = STATE_STREAM_DATA;
      end
      STATE_FINISHED: state_n = STATE_WAIT;
      default:        state_n = STATE_WAIT;
    endcase
  end

  // Bias alignment, floor shift back to the data format, and clamping.
  always_comb begin
    sum_c     = acc_n + (ACC_W'(bias_in) <<< FRAC_BITS);
    shifted_c = sum_c >>> FRAC_BITS;
    sat_c     = DATA_WIDTH'(shifted_c);
    if (shifted_c > SAT_MAX) sat_c = DATA_WIDTH'(SAT_MAX);
    if (shifted_c < SAT_MIN) sat_c = DATA_WIDTH'(SAT_MIN);
    rd_addr_c = ADDR_WIDTH'(row_n * IN_WIDTH) + col_n + tap_offset(cnt_n);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= STATE_WAIT;
      cnt                <= 4'd0;
      col                <= '0;
      row                <= '0;
      out_idx            <= '0;
      acc                <= '0;
      for (int i = 0; i < 9; i++) kernel[i] <= '0;
      read_address_out   <= '0;
      weight_address_out <= 4'd0;
      result_out         <= '0;
      write_address_out  <= '0;
      we_out             <= 1'b0;
      conv_done          <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      col       <= col_n;
      row       <= row_n;
      out_idx   <= idx_n;
      acc       <= acc_n;
      we_out    <= (state_n == STATE_WRITE);
      conv_done <= (state_n == STATE_FINISHED);
      if (state == STATE_LOAD_WEIGHTS && cnt != 4'd0) kernel[4'(cnt - 4'd1)] <= weight_in;
      if (state_n == STATE_LOAD_WEIGHTS)
        weight_address_out <= (cnt_n > 4'd8) ? 4'd8 : cnt_n;
      if (state_n == STATE_STREAM_DATA) read_address_out <= rd_addr_c;
      if (state_n == STATE_WRITE) begin
        result_out        <= sat_c;
        write_address_out <= idx_n;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_top.sv
// Bench for conv3x3_top: directed maps/kernels, RAM models, and a write scoreboard
// drained by a monitor whenever we_out is seen.
module tb_conv3x3_top;

  localparam int W   = 6;
  localparam int H   = 6;
  localparam int DW  = 16;
  localparam int AW  = 10;
  localparam int N   = (W - 2) * (H - 2);
  localparam int RUN_CYCLES = 1 + 10 + 11 * N;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 run;
  logic signed [DW-1:0] data_in;
  logic        [AW-1:0] read_address_out;
  logic signed [DW-1:0] weight_in;
  logic        [3:0]    weight_address_out;
  logic signed [DW-1:0] bias_in;
  logic signed [DW-1:0] result_out;
  logic        [AW-1:0] write_address_out;
  logic                 we_out;
  logic                 conv_done;

  conv3x3_top #(
    .IN_WIDTH(W), .IN_HEIGHT(H), .DATA_WIDTH(DW), .FRAC_BITS(8), .ADDR_WIDTH(AW)
  ) u_dut (
    .clk(clk), .reset(reset), .run(run),
    .data_in(data_in), .read_address_out(read_address_out),
    .weight_in(weight_in), .weight_address_out(weight_address_out),
    .bias_in(bias_in), .result_out(result_out),
    .write_address_out(write_address_out), .we_out(we_out), .conv_done(conv_done)
  );

  always #5 clk = ~clk;

  logic signed [DW-1:0] data_mem   [1024];
  logic signed [DW-1:0] weight_mem [16];

  // One-cycle synchronous read RAMs.
  always @(posedge clk) begin
    data_in   <= data_mem[read_address_out];
    weight_in <= weight_mem[weight_address_out];
  end

  typedef struct { int addr; int val; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   addr_log[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   we_count = 0;
  int   cyc;
  int   win5[9];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (we_out) begin
      we_count++;
      if (sb.size() == 0) begin
        check("unexpected_write", longint'(write_address_out), -1);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", longint'(write_address_out), mon_e.addr);
        check("wr_data", longint'(result_out), mon_e.val);
      end
    end
  end

  task automatic push_const(input int v);
    for (int o = 0; o < N; o++) sb.push_back('{o, v});
  endtask

  task automatic set_map(input logic signed [DW-1:0] pix, input logic signed [DW-1:0] wt_all,
                         input logic signed [DW-1:0] wt_center);
    for (int i = 0; i < W * H; i++) data_mem[i] = pix;
    for (int i = 0; i < 9; i++) weight_mem[i] = wt_all;
    weight_mem[4] = wt_center;
  endtask

  // Pulse run, then watch until conv_done, the abort point, or the cycle budget.
  task automatic do_run(input int inject_at, input int abort_at, output int cycles);
    addr_log.delete();
    cycles = 0;
    @(negedge clk);
    run = 1'b1;
    while (1) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      addr_log.push_back(int'(read_address_out));
      run = (inject_at > 0) && (cycles == inject_at || cycles == inject_at + 40);
      if (cycles == abort_at) begin
        reset = 1'b1;
        break;
      end
      if (conv_done || cycles >= 2000) break;
    end
    run = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_result"}, longint'(result_out), 0);
    check({tag, "_wr_addr"}, longint'(write_address_out), 0);
    check({tag, "_rd_addr"}, longint'(read_address_out), 0);
    check({tag, "_wt_addr"}, longint'(weight_address_out), 0);
    check({tag, "_we"}, longint'(we_out), 0);
    check({tag, "_done"}, longint'(conv_done), 0);
  endtask

  task automatic identity_setup();
    for (int i = 0; i < W * H; i++) data_mem[i] = DW'(i * 256);
    for (int i = 0; i < 9; i++) weight_mem[i] = '0;
    weight_mem[4] = 16'sd256;
    bias_in = '0;
    for (int o = 0; o < N; o++) sb.push_back('{o, ((o / (W - 2) + 1) * W + o % (W - 2) + 1) * 256});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    win5 = '{7, 8, 9, 13, 14, 15, 19, 20, 21};
    reset = 1'b1;
    run = 1'b0;
    bias_in = '0;
    for (int i = 0; i < 1024; i++) data_mem[i] = '0;
    for (int i = 0; i < 16; i++) weight_mem[i] = '0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Identity kernel: each output is the window centre pixel.
    identity_setup();
    do_run(0, 0, cyc);
    check("identity_done_cycles", cyc, RUN_CYCLES);
    check("identity_pending", sb.size(), 0);

    // All-ones kernel: 9 * 1.0 * 1.0 = 9.0, plus window address order of output 5.
    set_map(16'sd256, 16'sd256, 16'sd256);
    push_const(2304);
    do_run(0, 0, cyc);
    check("ones_done_cycles", cyc, RUN_CYCLES);
    check("ones_pending", sb.size(), 0);
    for (int j = 0; j < 9; j++) check("win5_rd_addr", addr_log[10 + 11 * 5 + j], win5[j]);

    // Positive and negative saturation.
    set_map(16'sh7FFF, 16'sh7FFF, 16'sh7FFF);
    push_const(32767);
    do_run(0, 0, cyc);
    check("satpos_pending", sb.size(), 0);
    set_map(16'sh7FFF, 16'sh8000, 16'sh8000);
    push_const(-32768);
    do_run(0, 0, cyc);
    check("satneg_pending", sb.size(), 0);

    // Bias and floor: (128 - 65536) >>> 8 = -256.
    set_map(16'sd1, 16'sd0, 16'sd128);
    bias_in = -16'sd256;
    push_const(-256);
    do_run(0, 0, cyc);
    check("bias_pending", sb.size(), 0);
    bias_in = '0;

    // Reset during output 2's streaming phase.
    set_map(16'sd256, 16'sd256, 16'sd256);
    push_const(2304);
    do_run(0, 10 + 22 + 3, cyc);
    #1;
    check_zero_outputs("midrun");
    check("midrun_outputs_written", N - sb.size(), 2);
    sb.delete();
    we_count = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    check("we_after_reset", we_count, 0);
    identity_setup();
    do_run(0, 0, cyc);
    check("post_reset_done_cycles", cyc, RUN_CYCLES);
    check("post_reset_pending", sb.size(), 0);

    // Back-to-back runs with a new kernel and ignored busy run pulses.
    set_map(16'sd256, 16'sd256, 16'sd256);
    push_const(2304);
    do_run(0, 0, cyc);
    check("b2b_first_pending", sb.size(), 0);
    set_map(16'sd256, 16'sd0, 16'sd256);
    push_const(256);
    do_run(5, 0, cyc);
    check("b2b_done_cycles", cyc, RUN_CYCLES);
    check("b2b_pending", sb.size(), 0);
    repeat (5) @(negedge clk);
    check("b2b_idle_done", longint'(conv_done), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
